// File: rtl/instr_queue.sv
// instr_queue: instruction prefetch queue between the fetch stage and the decoder.
// It holds {instr, pc} entries in a circular buffer and moves them over a
// valid/ready handshake. A taken-branch flush drops every buffered entry.
// A saturating counter records the cycles in which fetch is stalled.
module instr_queue #(
  parameter int depth       = 4,
  parameter int instr_width = 9,
  parameter int pc_width    = 8
) (
  input  logic                     clk,
  input  logic                     start,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [instr_width-1:0]   in_instr,
  input  logic [pc_width-1:0]      in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [instr_width-1:0]   out_instr,
  output logic [pc_width-1:0]      out_pc,
  input  logic                     out_ready,
  output logic [$clog2(depth):0]   count,
  output logic [15:0]              stall_count
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] full_count = cnt_w'(depth);

  logic [instr_width-1:0] mem_instr [depth];
  logic [pc_width-1:0]    mem_pc    [depth];
  logic [ptr_w-1:0]       wr_ptr;
  logic [ptr_w-1:0]       rd_ptr;
  logic                   push;
  logic                   pop;
  logic                   clear;

  // Handshake qualifiers. Ready and valid come from registered occupancy
  // only, so a full queue never accepts a word in the cycle it is drained.
  assign in_ready  = (count != full_count);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign clear     = start | flush;

  // Pointer and occupancy state. A flush or start discards the push or pop
  // presented in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage. A word presented during a flush is not stored.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; occupancy alone decides which
    // entries are meaningful, so stale contents are never visible.
    if (push && !clear) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  // Saturating count of cycles in which fetch offered a word that was refused.
  // Only start clears it; a flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (start) begin
      stall_count <= '0;
    end else if (!flush && in_valid && !in_ready && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  // Head word. The decoder sees an all-zero bubble while the queue is empty.
  always_comb begin
    // NOTE: defaults first so that every path assigns both outputs and no
    // latch is inferred.
    out_instr = '0;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = mem_instr[rd_ptr];
      out_pc    = mem_pc[rd_ptr];
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed scenarios followed by random traffic on instr_queue.
// All outputs are compared with a queue-based reference model after each edge.
module tb_instr_queue;

  localparam int depth = 4;

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_instr = '0;
  logic [7:0]  in_pc = '0;
  logic        in_ready;
  logic        out_valid;
  logic [8:0]  out_instr;
  logic [7:0]  out_pc;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
  logic [15:0] stall_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: a plain FIFO of {instr, pc} and an integer stall tally.
  logic [16:0] model_q[$];
  int          model_stall = 0;

  instr_queue #(.depth(depth), .instr_width(9), .pc_width(8)) dut (
    .clk         (clk),
    .start       (start),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .count       (count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output with the model's view of the queue.
  task automatic check_all();
    int n;
    n = model_q.size();
    check("count", 32'(count), 32'(n));
    check("in_ready", 32'(in_ready), 32'(n != depth));
    check("out_valid", 32'(out_valid), 32'(n != 0));
    check("out_instr", 32'(out_instr), (n != 0) ? 32'(model_q[0][16:8]) : 32'd0);
    check("out_pc", 32'(out_pc), (n != 0) ? 32'(model_q[0][7:0]) : 32'd0);
    check("stall_count", 32'(stall_count), 32'(model_stall));
  endtask

  // Apply one cycle of inputs, advance the model on the edge, check after it.
  task automatic step(input logic s, input logic f, input logic iv,
                      input logic [8:0] ins, input logic [7:0] p, input logic ordy);
    bit do_push;
    bit do_pop;
    start = s; flush = f; in_valid = iv; in_instr = ins; in_pc = p; out_ready = ordy;
    @(posedge clk);
    if (s) begin
      model_q.delete();
      model_stall = 0;
    end else if (f) begin
      model_q.delete();
    end else begin
      do_push = iv && (model_q.size() < depth);
      do_pop  = ordy && (model_q.size() > 0);
      if (iv && model_q.size() == depth && model_stall < 65535) model_stall++;
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({ins, p});
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset and fill.
    step(1, 0, 0, 9'h0, 8'h0, 0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 9'(9'h101 + i), 8'(i), 0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", 32'(out_instr), 32'h101);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 9'h1FF, 8'hFF, 0);
    check("stall_3", 32'(stall_count), 32'd3);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      check("drain_head", 32'(out_instr), 32'(9'h101 + i));
      step(0, 0, 0, 9'h0, 8'h0, 1);
    end
    check("drained_valid", 32'(out_valid), 32'd0);

    // Streaming with wrap: count stays at 1 while pc 0..9 flows through.
    step(1, 0, 0, 9'h0, 8'h0, 0);
    step(0, 0, 1, 9'h0A0, 8'd0, 0);
    for (int i = 1; i < 10; i++) begin
      check("stream_pc", 32'(out_pc), 32'(i - 1));
      step(0, 0, 1, 9'(9'h0A0 + i), 8'(i), 1);
      check("stream_count", 32'(count), 32'd1);
    end
    check("stream_last_pc", 32'(out_pc), 32'd9);
    step(0, 0, 0, 9'h0, 8'h0, 1);

    // Flush with simultaneous push.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 9'(9'h010 + i), 8'(8'h20 + i), 0);
    step(0, 1, 1, 9'h1AA, 8'h33, 0);
    check("flush_count", 32'(count), 32'd0);
    step(0, 0, 1, 9'h055, 8'h44, 0);
    check("post_flush_head", 32'(out_instr), 32'h055);

    // Saturation and reset priority.
    step(1, 0, 0, 9'h0, 8'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 9'(i), 8'(i), 0);
    for (int i = 0; i < 70000; i++) step(0, 0, 1, 9'h1, 8'h1, 0);
    check("stall_sat", 32'(stall_count), 32'hFFFF);
    step(0, 1, 1, 9'h1, 8'h1, 0);
    check("stall_after_flush", 32'(stall_count), 32'hFFFF);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 9'(i), 8'(i), 0);
    step(1, 1, 1, 9'h1, 8'h1, 0);
    check("start_flush_count", 32'(count), 32'd0);
    check("start_flush_stall", 32'(stall_count), 32'd0);

    // Random traffic with occasional flush and start.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 3) != 0), 9'($urandom), 8'($urandom),
           1'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Parameterised instruction prefetch queue between the fetch stage and the decoder of the 9-bit-instruction core. It buffers fetched instruction words with their PC over a valid/ready handshake. It discards all buffered entries when a taken branch or jump redirects fetch. It also keeps a saturating count of fetch-side stall cycles for performance bring-up.

## Interface

Parameters:
- `depth`, default 4: number of queue entries; power of two, minimum 2.
- `instr_width`, default 9: instruction word width.
- `pc_width`, default 8: program-counter width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `start`  in  1  synchronous, active-high reset.
- `flush`  in  1  taken-branch/jump redirect; drops all buffered entries.
- `in_valid`  in  1  fetch side presents a word.
- `in_instr`  in  instr_width  fetched instruction.
- `in_pc`  in  pc_width  PC of `in_instr`.
- `in_ready`  out  1  queue accepts a word this cycle.
- `out_valid`  out  1  head entry valid for the decoder.
- `out_instr`  out  instr_width  head instruction.
- `out_pc`  out  pc_width  head PC.
- `out_ready`  in  1  decoder consumes the head this cycle.
- `count`  out  $clog2(depth)+1  current occupancy, 0..depth.
- `stall_count`  out  16  cycles with `in_valid & ~in_ready`; saturates at 16'hFFFF.

## Operation

- **Storage.** Circular buffer of `depth` entries, each {instr, pc}. Pointers `wr_ptr` and `rd_ptr` are $clog2(depth) bits and wrap modulo `depth`. Occupancy is held in `count`.
- **Push.** A push occurs when `in_valid & in_ready`. It writes the entry at `wr_ptr` and advances `wr_ptr`.
- **Pop.** A pop occurs when `out_valid & out_ready`. It advances `rd_ptr`.
- **Ready.** `in_ready = (count != depth)`. It is combinational from registered state only and never depends on `out_ready`, so there is no full-queue pass-through.
- **Valid.** `out_valid = (count != 0)`.
- **Head outputs.** `out_instr` and `out_pc` show the entry at `rd_ptr` while `out_valid` is 1. They are forced to 0 while `out_valid` is 0, so the decoder sees an all-zero bubble word.
- **Occupancy update.**
  - Push without pop: `count + 1`.
  - Pop without push: `count - 1`.
  - Push and pop together: unchanged, and both pointers advance.
- **Flush.**
  - Next cycle: `count = 0` and `rd_ptr = wr_ptr = 0`.
  - A push or pop presented in the flush cycle is discarded; the word is lost and the pointers do not advance.
  - Data RAM contents are not cleared.
  - `stall_count` is unaffected.
- **`start` reset.** Same effect as flush, and additionally clears `stall_count`. When `start` and `flush` are asserted together, `start` behaviour applies.
- **Stall counter.** `stall_count` increments by 1 on each cycle with `in_valid & ~in_ready`. This excludes cycles where `start` or `flush` is asserted. It holds at 16'hFFFF once reached.
- **Ignored inputs.**
  - `in_valid` while full: ignored, but counted as a stall.
  - `out_ready` while empty: ignored.

## Timing

- **Reset values** (after a cycle with `start`=1):
  - `count` = 0, `out_valid` = 0, `in_ready` = 1.
  - `out_instr` = 0, `out_pc` = 0, `stall_count` = 0.
- **Latency.** A word pushed at edge N appears at the head with `out_valid` = 1 after edge N. There is no combinational bypass, so minimum latency is 1 cycle.
- **Throughput.** One push and one pop per cycle sustained when 0 < `count` < `depth`.
- **Full.** After the push that makes `count = depth`, `in_ready` is 0 for the next cycle. A pop in that cycle restores `in_ready` = 1 in the following cycle.
- **Empty.** After the pop that makes `count` = 0, `out_valid` is 0 in the next cycle.
- **Pointer wrap.** Index `depth-1` is followed by index 0, with no bubble.
- **Flush or reset mid-stream.** The outputs take the reset values listed above on the cycle after the asserting edge (`stall_count` only on `start`). A new push in that following cycle is accepted normally.
- **Mid-operation reset.** `start` asserted at any occupancy empties the queue within one edge.

## Test plan

- **Reset and fill.** Reset, then push instr 9'h101..9'h104 with pc 0..3 and `out_ready` = 0. Required:
  - `count` goes 1, 2, 3, 4.
  - `in_ready` = 0 after the 4th push.
  - Head shows 9'h101 / pc 0.
  - Holding `in_valid` = 1 for 3 more cycles gives `stall_count` = 3.
- **Drain in order.** From full, hold `out_ready` = 1. Required:
  - Heads appear as 9'h101, 9'h102, 9'h103, 9'h104 on consecutive cycles.
  - Then `out_valid` = 0 with `out_instr` = 0 and `count` = 0.
- **Streaming with wrap.** Push every cycle and pop every cycle, starting from `count` = 1, for 10 words (pc 0..9). Required:
  - `count` stays at 1.
  - Output pc sequence is 0..9 with no gaps.
  - Pointers wrap twice.
- **Flush with simultaneous push.** Hold 3 entries; assert `flush` with `in_valid` = 1 carrying 9'h1AA. Required:
  - Next cycle `count` = 0 and `out_valid` = 0; 9'h1AA is not stored.
  - A push of 9'h055 on the following cycle appears at the head one cycle later.
- **Saturation and reset priority.** Force 70000 stall cycles. Required:
  - `stall_count` = 16'hFFFF and holds.
  - `flush` leaves it at 16'hFFFF.
  - `start` together with `flush` clears `count` and `stall_count` to 0.
